instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, asynchronous and active-low.
- REQ-003: Parameter AW, default 10, word-address width of the instruction memory write port.
- REQ-004: Parameter MAX_WORDS, default 1024, largest accepted program length in 32-bit words, at most 2**AW.
- REQ-005: start  input  1  one-cycle pulse that begins a load session.
- REQ-006: byte_valid  input  1  byte_data holds a valid stream byte.
- REQ-007: byte_data  input  8  program stream byte.
- REQ-008: byte_ready  output  1  loader accepts a byte this cycle.
- REQ-009: imem_we  output  1  instruction memory write strobe.
- REQ-010: imem_adr  output  AW  instruction memory word address.
- REQ-011: imem_wdata  output  32  instruction word written.
- REQ-012: cpu_reset  output  1  active-high hold of the processor pipeline, driving the PC and pipeline-register reset.
- REQ-013: done  output  1  load completed successfully.
- REQ-014: error  output  1  load aborted.
- REQ-015: word_count  output  AW+1  number of words written in the current session.

Function
- REQ-016: A byte transfers only in a cycle where byte_valid=1 and byte_ready=1.
- REQ-017: Stream format: LEN_LO, LEN_HI (16-bit N, word count, little-endian), then 4*N payload bytes, each word little-endian (first byte goes to bits [7:0]).
- REQ-018: FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
- REQ-019: byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHK.
- REQ-020: IDLE, DONE and ERROR move to LEN_LO on start=1, clearing done, error, word_count and imem_adr; start is ignored in every other state.
- REQ-021: LEN_HI accept: N>MAX_WORDS goes to ERROR; N=0 goes to the end-of-payload target (REQ-031); otherwise goes to DATA.
- REQ-022: DATA: on the 4th byte of a word, imem_we=1 for exactly one cycle in the following cycle, with the assembled word on imem_wdata and the current address on imem_adr.
- REQ-023: After each write, imem_adr and word_count increment by 1; imem_adr starts at 0 and never wraps because N<=MAX_WORDS.
- REQ-024: byte_ready stays 1 during the write cycle; back-to-back bytes sustain one byte per clock.
- REQ-025: After the Nth word is accepted, the FSM leaves DATA.
- REQ-026: cpu_reset=1 in every state except DONE; it returns to 1 when a new start is accepted.
- REQ-027: done=1 only in DONE; error=1 only in ERROR; both are held until the next start.

Reset
- REQ-028: While rst=0: state IDLE, byte_ready=0, imem_we=0, imem_adr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0, partial word and byte counter cleared.
- REQ-029: rst asserted mid-session aborts the session immediately, with no further imem_we and no partial word written.
- REQ-030: After rst deasserts, the loader waits in IDLE for start.

Configuration
- REQ-031: With LOADER_CHECKSUM_EN defined: after the payload (or after LEN_HI when N=0), the FSM enters CHK and accepts one byte; the byte must equal the XOR of LEN_LO, LEN_HI and all payload bytes; a match goes to DONE, a mismatch goes to ERROR, and words already written remain.
- REQ-032: With LOADER_CHECKSUM_EN undefined: the CHK state and XOR accumulator are absent, and the end of payload goes directly to DONE.

Structure
- REQ-033: Package loader_pkg holds the state enum, LEN header byte count (2), BYTES_PER_WORD (4) and the checksum width.
- REQ-034: Sub-module byte_assembler holds the 2-bit byte counter, the 32-bit little-endian packer and the word_ready pulse; instr_loader holds the FSM, address/count counters and checksum.

Verification
- REQ-035: start; stream 02 00 13 00 00 00 B3 80 20 00 -> imem_we at adr 0 with 0x00000013, then at adr 1 with 0x002080B3; done=1; cpu_reset falls to 0; word_count=2.
- REQ-036: start; stream 00 00 -> no imem_we; done=1 (without LOADER_CHECKSUM_EN).
- REQ-037: N=MAX_WORDS+1 (MAX_WORDS=1024: 01 04) -> ERROR after LEN_HI; no imem_we; cpu_reset=1; byte_ready=0.
- REQ-038: byte_valid toggled randomly during payload -> identical words and addresses as with the continuous stream; start pulsed mid-DATA is ignored.
- REQ-039: rst=0 after 6 payload bytes of a 2-word program -> exactly one imem_we was issued; all outputs at reset values; a new start reloads from adr 0.
- REQ-040: With LOADER_CHECKSUM_EN: stream 01 00 13 00 00 00 then 12 -> done=1; the same stream with final byte 13 -> error=1, and the word at adr 0 was still written.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encodings and stream framing constants for the program loader.
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CHK    = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CHK_W          = 8;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs accepted stream bytes into little-endian 32-bit words.
// word_ready pulses in the cycle after the last byte of a word, with word holding the result.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word,
  output logic        byte_last
);

  logic [1:0]  cnt;
  logic [23:0] partial;

  assign byte_last = (cnt == 2'(BYTES_PER_WORD - 1));

  // partial shifts right so the first byte of a word ends up in bits [7:0]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 2'd0;
      partial    <= 24'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else if (clear) begin
      cnt        <= 2'd0;
      partial    <= 24'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= byte_en && byte_last;
      if (byte_en) begin
        cnt <= cnt + 2'd1;
        if (byte_last) begin
          word <= {byte_data, partial};
        end else begin
          partial <= {byte_data, partial[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams a length-prefixed program into instruction memory, holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int AW        = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_adr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error,
  output logic [AW:0]   word_count
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_END = ST_CHK;
`else
  localparam state_t ST_END = ST_DONE;
`endif

  state_t                   state;
  logic                     xfer;
  logic                     session_start;
  logic                     byte_last;
  logic                     word_ready;
  logic [CHK_W-1:0]         len_lo;
  logic [8*LEN_BYTES-1:0]   n_field;
  logic [AW:0]              len_last;

  assign byte_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHK);
  assign xfer          = byte_valid && byte_ready;
  assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign n_field       = {byte_data, len_lo};

  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);
  assign cpu_reset = (state != ST_DONE);
  assign imem_we   = word_ready;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (session_start),
    .byte_en    (xfer && (state == ST_DATA)),
    .byte_data  (byte_data),
    .word_ready (word_ready),
    .word       (imem_wdata),
    .byte_last  (byte_last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [CHK_W-1:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (session_start) begin
      csum <= '0;
    end else if (xfer && (state != ST_CHK)) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      imem_adr   <= '0;
      word_count <= '0;
      len_lo     <= '0;
      len_last   <= '0;
    end else begin
      if (word_ready) begin
        imem_adr   <= imem_adr + AW'(1);
        word_count <= word_count + (AW+1)'(1);
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LEN_LO;
            imem_adr   <= '0;
            word_count <= '0;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len_lo <= byte_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_last <= (AW+1)'(32'(n_field) - 32'd1);
            if (32'(n_field) > MAX_WORDS) begin
              state <= ST_ERROR;
            end else if (n_field == '0) begin
              state <= ST_END;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // the previous word's write has always retired before the next word completes
          if (xfer && byte_last && (word_count == len_last)) begin
            state <= ST_END;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            state <= (byte_data == csum) ? ST_DONE : ST_ERROR;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader (LOADER_CHECKSUM_EN aware).
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [9:0]  imem_adr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wr_adr[$];
  logic [31:0] wr_dat[$];

  always #5 clk = ~clk;

  instr_loader #(.AW(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_adr   (imem_adr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_adr.push_back(imem_adr);
      wr_dat.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] xsum(input logic [7:0] s[$]);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction
`endif

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 0);
  endtask

  task automatic test_reset;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b required 0", imem_we); end
    checks++; if (imem_adr !== 10'd0) begin errors++; $display("FAIL reset_imem_adr: got %h required 0", imem_adr); end
    checks++; if (imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_imem_wdata: got %h required 0", imem_wdata); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b required 1", cpu_reset); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b/%b required 0/0", done, error); end
    checks++; if (word_count !== 11'd0) begin errors++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
  endtask

  task automatic test_basic;
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xsum(s));
`endif
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_adr.size() != 2) begin
      errors++; $display("FAIL basic_write_count: got %0d required 2", wr_adr.size());
    end else begin
      checks++; if (wr_adr[0] !== 10'd0 || wr_dat[0] !== 32'h00000013) begin errors++; $display("FAIL basic_word0: got adr %h data %h required 0 / 00000013", wr_adr[0], wr_dat[0]); end
      checks++; if (wr_adr[1] !== 10'd1 || wr_dat[1] !== 32'h002080B3) begin errors++; $display("FAIL basic_word1: got adr %h data %h required 1 / 002080b3", wr_adr[1], wr_dat[1]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%b error=%b required 1/0", done, error); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_reset: got %b required 0", cpu_reset); end
    checks++; if (word_count !== 11'd2) begin errors++; $display("FAIL basic_word_count: got %0d required 2", word_count); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL basic_byte_ready: got %b required 0", byte_ready); end
  endtask

  task automatic test_restart_zero_len;
    logic [7:0] s[$];
    s = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xsum(s));
`endif
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    checks++; if (done !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 11'd0 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL restart_clear: got done=%b cpu_reset=%b word_count=%0d byte_ready=%b required 0/1/0/1", done, cpu_reset, word_count, byte_ready);
    end
    send_stream(s);
    repeat (3) @(negedge clk);
    checks++; if (wr_adr.size() != 0) begin errors++; $display("FAIL zero_len_writes: got %0d required 0", wr_adr.size()); end
    checks++; if (done !== 1'b1 || word_count !== 11'd0) begin errors++; $display("FAIL zero_len_done: got done=%b word_count=%0d required 1/0", done, word_count); end
  endtask

  task automatic test_too_long;
    logic [7:0] s[$];
    s = '{8'h01, 8'h04};
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL too_long_error: got error=%b done=%b required 1/0", error, done); end
    checks++; if (wr_adr.size() != 0) begin errors++; $display("FAIL too_long_writes: got %0d required 0", wr_adr.size()); end
    checks++; if (cpu_reset !== 1'b1 || byte_ready !== 1'b0) begin errors++; $display("FAIL too_long_outputs: got cpu_reset=%b byte_ready=%b required 1/0", cpu_reset, byte_ready); end
  endtask

  task automatic test_gaps_and_start;
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xsum(s));
`endif
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], int'($urandom_range(0, 3)));
      if (i == 4) pulse_start;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_adr.size() != 2) begin
      errors++; $display("FAIL gaps_write_count: got %0d required 2", wr_adr.size());
    end else begin
      checks++; if (wr_adr[0] !== 10'd0 || wr_dat[0] !== 32'h00000013) begin errors++; $display("FAIL gaps_word0: got adr %h data %h required 0 / 00000013", wr_adr[0], wr_dat[0]); end
      checks++; if (wr_adr[1] !== 10'd1 || wr_dat[1] !== 32'h002080B3) begin errors++; $display("FAIL gaps_word1: got adr %h data %h required 1 / 002080b3", wr_adr[1], wr_dat[1]); end
    end
    checks++; if (done !== 1'b1 || word_count !== 11'd2) begin errors++; $display("FAIL gaps_done: got done=%b word_count=%0d required 1/2", done, word_count); end
  endtask

  task automatic test_reset_mid_session;
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80};
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_adr.size() != 1) begin errors++; $display("FAIL rst_mid_writes: got %0d required 1", wr_adr.size()); end
    checks++; if (byte_ready !== 1'b0 || imem_we !== 1'b0 || imem_adr !== 10'd0 || imem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_mid_datapath: got byte_ready=%b imem_we=%b adr=%h wdata=%h required 0/0/0/0", byte_ready, imem_we, imem_adr, imem_wdata);
    end
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 11'd0) begin
      errors++; $display("FAIL rst_mid_status: got cpu_reset=%b done=%b error=%b word_count=%0d required 1/0/0/0", cpu_reset, done, error, word_count);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_wait: got byte_ready=%b required 0", byte_ready); end
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(xsum(s));
`endif
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_adr.size() != 2) begin
      errors++; $display("FAIL reload_write_count: got %0d required 2", wr_adr.size());
    end else begin
      checks++; if (wr_adr[0] !== 10'd0 || wr_dat[0] !== 32'h00000013) begin errors++; $display("FAIL reload_word0: got adr %h data %h required 0 / 00000013", wr_adr[0], wr_dat[0]); end
      checks++; if (wr_adr[1] !== 10'd1 || wr_dat[1] !== 32'h002080B3) begin errors++; $display("FAIL reload_word1: got adr %h data %h required 1 / 002080b3", wr_adr[1], wr_dat[1]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b required 1", done); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] s[$];
    s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL chk_good: got done=%b error=%b required 1/0", done, error); end
    s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    wr_adr.delete(); wr_dat.delete();
    pulse_start;
    send_stream(s);
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL chk_bad: got error=%b done=%b required 1/0", error, done); end
    checks++;
    if (wr_adr.size() != 1) begin
      errors++; $display("FAIL chk_bad_writes: got %0d required 1", wr_adr.size());
    end else if (wr_adr[0] !== 10'd0 || wr_dat[0] !== 32'h00000013) begin
      errors++; $display("FAIL chk_bad_word0: got adr %h data %h required 0 / 00000013", wr_adr[0], wr_dat[0]);
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_basic;
    test_restart_zero_len;
    test_too_long;
    test_gaps_and_start;
    test_reset_mid_session;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
